ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Execute-stage consumer of the ID/EX pipeline register outputs.
- Performs iterative unsigned multiply (MULTU) and unsigned divide (DIVU) on the latched RS/RT operands and writes the result into HI/LO.
- Drives busy_o back to the hazard unit, which holds the IF/ID and ID/EX registers while an operation is in flight.
- Emits a one-cycle done_o pulse with the destination address for writeback.

Parameters:
- WIDTH, 32, operand and HI/LO width
- CNT_W, 6, iteration counter width; must hold the value WIDTH

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- start_i  input  1  request from ID/EX; sampled on the rising edge
- op_i  input  2  operation: 01 MULTU, 10 DIVU, 00/11 no-op
- RSdata_i  input  WIDTH  multiplicand or dividend
- RTdata_i  input  WIDTH  multiplier or divisor
- RDaddr_i  input  5  destination tag, carried through to writeback
- flush_i  input  1  abort the in-flight operation
- busy_o  output  1  operation in flight; stall request to the hazard unit
- done_o  output  1  one-cycle completion pulse
- hi_o  output  WIDTH  product high word, or remainder
- lo_o  output  WIDTH  product low word, or quotient
- RDaddr_o  output  5  tag of the completed operation; valid while done_o=1

Behaviour:
- Reset: asynchronous, takes effect immediately on rst_i=1 regardless of state or clock.
  - FSM goes to IDLE; counter=0.
  - busy_o=0, done_o=0, hi_o=0, lo_o=0, RDaddr_o=0.
  - All internal operand and accumulator registers clear to 0.
  - Reset asserted mid-operation discards the operation; no done_o follows.
- FSM states: IDLE, MUL, DIV, DONE.
- Accept condition: start_i=1, op_i in {01,10}, state in {IDLE, DONE}, flush_i=0.
  - Latch RSdata_i, RTdata_i and RDaddr_i (internal copy); counter=0.
  - Go to MUL (op 01) or DIV (op 10).
  - If op=10 and RTdata_i=0, go directly to DONE instead (see divide-by-zero).
- start_i in MUL/DIV is ignored; the hazard unit guarantees it is held stable.
- start_i with op 00/11 is ignored; the FSM stays in or returns to IDLE.
- MUL: one shift-add step per edge.
  - If multiplier bit0=1, add the multiplicand into the upper half of a 2*WIDTH accumulator; take the carry into the top.
  - Shift the accumulator and multiplier right by 1.
- DIV: restoring division, one quotient bit per edge.
  - Shift {remainder, dividend} left by 1.
  - If remainder >= divisor: subtract, and quotient bit=1.
- Counter increments every iteration edge.
  - On the edge that completes iteration WIDTH: hi_o/lo_o load the result, RDaddr_o loads the latched tag, state goes to DONE.
- Latency: accept edge E0; iterations at E1..E32; DONE during the cycle after E32.
  - done_o is high exactly 32 cycles after the accepting edge, for one cycle.
- busy_o: 1 exactly when state in {MUL, DIV}; 32 cycles per operation.
- done_o: 1 exactly when state=DONE.
- DONE behaviour:
  - Exits next edge to IDLE, or to MUL/DIV if a new start is accepted on that edge.
  - Back-to-back operations lose no cycle.
- Divide-by-zero: the next cycle is DONE with hi_o=RSdata_i, lo_o=all ones, busy_o never asserted.
- flush_i=1:
  - In MUL/DIV: next state IDLE; hi_o, lo_o and RDaddr_o unchanged; no done_o.
  - In IDLE or DONE: blocks acceptance that edge; next state IDLE.
  - flush_i has priority over start_i.
- hi_o/lo_o change only on a completion edge and hold until the next completion.
- All arithmetic is unsigned and modulo 2*WIDTH; no overflow flag.

Test Plan:
- Reset, then MULTU 3*5 with RDaddr=7 → busy_o high 32 cycles; done_o pulses 32 cycles after accept; lo_o=0x0000000F, hi_o=0, RDaddr_o=7.
- MULTU 0xFFFFFFFF*0xFFFFFFFF → hi_o=0xFFFFFFFE, lo_o=0x00000001.
- DIVU 100/7 → lo_o=14, hi_o=2, 32-cycle latency; then DIVU 0x12345678/0 → done_o one cycle after accept, busy_o stays 0, hi_o=0x12345678, lo_o=0xFFFFFFFF.
- Start MULTU 6*7 (previous hi_o/lo_o=2/14), assert flush_i on the 10th busy cycle → busy_o=0 the next cycle, no done_o, hi_o/lo_o remain 2/14.
- Assert rst_i asynchronously mid-DIVU (between edges) → busy_o, hi_o and lo_o go to 0 immediately; no done_o follows.
- MULTU 2*3 completes, and start_i for DIVU 9/2 is held during the DONE cycle → accepted with no gap; second done_o 32 cycles later with lo_o=4, hi_o=1.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative unsigned multiply/divide unit writing HI/LO for the execute stage
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] RSdata_i,
    input  logic [WIDTH-1:0] RTdata_i,
    input  logic [4:0]       RDaddr_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [4:0]       RDaddr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opa;        // multiplicand or divisor
    logic [WIDTH-1:0]   opb;        // multiplier, consumed one bit per step
    logic [2*WIDTH-1:0] acc;        // product, or {remainder, dividend/quotient}
    logic [4:0]         tag;

    logic               accept;
    logic               div_zero;
    logic               iterating;
    logic               last_iter;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        accept    = start_i && ((op_i == OP_MULTU) || (op_i == OP_DIVU))
                    && ((state == S_IDLE) || (state == S_DONE)) && !flush_i;
        div_zero  = (op_i == OP_DIVU) && (RTdata_i == '0);
        iterating = (state == S_MUL) || (state == S_DIV);
        last_iter = (cnt == CNT_W'(WIDTH - 1));
    end

    // One shift-add multiply step or one restoring-divide step on acc.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opb[0] ? {1'b0, opa} : '0);
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        rem_diff  = rem_shift - {1'b0, opa};
        acc_step  = '0;
        if (state == S_MUL) begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end else if (rem_shift >= {1'b0, opa}) begin
            acc_step = {rem_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_step = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (op_i == OP_MULTU) begin
                        state_nxt = S_MUL;
                    end else if (div_zero) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_DIV;
                    end
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                if (flush_i) begin
                    state_nxt = S_IDLE;
                end else if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = iterating;
        done_o = (state == S_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            tag      <= '0;
            hi_o     <= '0;
            lo_o     <= '0;
            RDaddr_o <= '0;
        end else if (accept) begin
            cnt <= '0;
            tag <= RDaddr_i;
            if (op_i == OP_MULTU) begin
                opa <= RSdata_i;
                opb <= RTdata_i;
                acc <= '0;
            end else begin
                opa <= RTdata_i;
                opb <= '0;
                acc <= {{WIDTH{1'b0}}, RSdata_i};
            end
            // Divide by zero bypasses iteration and completes on the next cycle.
            if (div_zero) begin
                hi_o     <= RSdata_i;
                lo_o     <= '1;
                RDaddr_o <= RDaddr_i;
            end
        end else if (iterating && !flush_i) begin
            acc <= acc_step;
            opb <= opb >> 1;
            cnt <= cnt + CNT_W'(1);
            if (last_iter) begin
                hi_o     <= acc_step[2*WIDTH-1:WIDTH];
                lo_o     <= acc_step[WIDTH-1:0];
                RDaddr_o <= tag;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - directed and random checks of ex_muldiv_unit against an arithmetic model
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic [4:0]  rd = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [4:0]  rd_out;

    int errors = 0;
    int checks = 0;

    ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .op_i     (op),
        .RSdata_i (rs),
        .RTdata_i (rt),
        .RDaddr_i (rd),
        .flush_i  (flush),
        .busy_o   (busy),
        .done_o   (done),
        .hi_o     (hi),
        .lo_o     (lo),
        .RDaddr_o (rd_out)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
        if (mop == 2'b01) return {32'd0, a} * {32'd0, b};
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
    endfunction

    task automatic check(input string name, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, observed, expected);
        end
    endtask

    task automatic wait_done(output int k_done, output int busy_cnt);
        k_done   = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                k_done = k;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
        int          k_done;
        int          busy_cnt;
        int          exp_lat;
        logic [63:0] exp;
        exp     = model(mop, a, b);
        exp_lat = (mop == 2'b10 && b == 32'd0) ? 0 : 32;
        @(negedge clk);
        start = 1'b1; op = mop; rs = a; rt = b; rd = tag;
        @(negedge clk);
        start = 1'b0; op = 2'b00;
        wait_done(k_done, busy_cnt);
        check("done_latency", 64'(k_done - 1), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_lat));
        check("hi", {32'd0, hi}, {32'd0, exp[63:32]});
        check("lo", {32'd0, lo}, {32'd0, exp[31:0]});
        check("rd_out", 64'(rd_out), 64'(tag));
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        int          k_done;
        int          busy_cnt;
        int          seen;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_rd", 64'(rd_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(2'b01, 32'd3, 32'd5, 5'd7);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
        run_op(2'b10, 32'd100, 32'd7, 5'd2);
        run_op(2'b10, 32'h1234_5678, 32'd0, 5'd5);

        // Ignored start with an undefined opcode
        @(negedge clk);
        start = 1'b1; op = 2'b11; rs = 32'd9; rt = 32'd9;
        @(negedge clk);
        start = 1'b0; op = 2'b00;
        check("noop_busy", 64'(busy), 64'd0);
        check("noop_done", 64'(done), 64'd0);

        for (int i = 0; i < 10; i++) begin
            rop = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, 5'($urandom_range(0, 31)));
        end

        // Flush on the 10th busy cycle
        run_op(2'b10, 32'd100, 32'd7, 5'd3);
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs = 32'd6; rt = 32'd7; rd = 5'd9;
        @(negedge clk);
        start = 1'b0; op = 2'b00;
        repeat (9) @(negedge clk);
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_after", 64'(busy), 64'd0);
        check("flush_done_after", 64'(done), 64'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("flush_no_done", 64'(seen), 64'd0);
        check("flush_hi", 64'(hi), 64'd2);
        check("flush_lo", 64'(lo), 64'd14);
        check("flush_rd", 64'(rd_out), 64'd3);

        // Asynchronous reset between edges mid-divide
        @(negedge clk);
        start = 1'b1; op = 2'b10; rs = 32'h1000; rt = 32'd3; rd = 5'd4;
        @(negedge clk);
        start = 1'b0; op = 2'b00;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_rd", 64'(rd_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        check("arst_no_done", 64'(seen), 64'd0);

        // Back-to-back: DIVU accepted on the DONE cycle of a MULTU
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs = 32'd2; rt = 32'd3; rd = 5'd11;
        @(negedge clk);
        start = 1'b0; op = 2'b00;
        wait_done(k_done, busy_cnt);
        check("b2b_first_latency", 64'(k_done - 1), 64'd32);
        check("b2b_first_hi", 64'(hi), 64'd0);
        check("b2b_first_lo", 64'(lo), 64'd6);
        check("b2b_first_rd", 64'(rd_out), 64'd11);
        start = 1'b1; op = 2'b10; rs = 32'd9; rt = 32'd2; rd = 5'd12;
        @(negedge clk);
        check("b2b_no_gap_busy", 64'(busy), 64'd1);
        check("b2b_no_gap_done", 64'(done), 64'd0);
        start = 1'b0; op = 2'b00;
        wait_done(k_done, busy_cnt);
        check("b2b_second_latency", 64'(k_done - 1), 64'd32);
        check("b2b_second_busy", 64'(busy_cnt), 64'd32);
        check("b2b_second_hi", 64'(hi), 64'd1);
        check("b2b_second_lo", 64'(lo), 64'd4);
        check("b2b_second_rd", 64'(rd_out), 64'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
